alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters:
  - Requester 0: execute stage, high priority.
  - Requester 1: secondary unit, e.g. address-generation or debug engine.
- Each requester issues an operation through a valid/ready request channel and receives the registered result and flags on its own valid/ready response channel.
- Sits between the requesters and the ALU's op/operand/flag signals. A starvation counter bounds requester 1's wait.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/alu_rsp_slot.sv | 31 +++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: ALU word, operation encoding and the registered
// ALU response record used by the arbiter's response slots.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;

    // Operation presented to the ALU when nobody owns it this cycle.
    localparam aluop_t ALU_IDLE_OP = ALU_ADD;

    typedef struct packed {
        word_t result;
        logic  zero;
        logic  negative;
        logic  overflow;
    } alu_rsp_t;

endpackage

// File: rtl/alu_rsp_slot.sv
// One registered ALU response with valid/ready hold: loaded on grant, cleared
// when the consumer takes it, data frozen while it waits.
module alu_rsp_slot
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     load,
    input  alu_rsp_t din,
    input  logic     rsp_ready,
    output logic     free,
    output logic     rsp_valid,
    output alu_rsp_t rsp
);

    // A full slot being drained this cycle can take a new result without a bubble.
    assign free = !rsp_valid || rsp_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp_valid <= 1'b0;
            rsp       <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp       <= din;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (req0, priority) and
// a secondary unit (req1) whose wait is bounded by a starvation counter.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   req0_valid,
    input  aluop_t req0_op,
    input  word_t  req0_a,
    input  word_t  req0_b,
    output logic   req0_ready,
    input  logic   req1_valid,
    input  aluop_t req1_op,
    input  word_t  req1_a,
    input  word_t  req1_b,
    output logic   req1_ready,
    output logic   rsp0_valid,
    output word_t  rsp0_result,
    output logic   rsp0_zero,
    output logic   rsp0_negative,
    output logic   rsp0_overflow,
    input  logic   rsp0_ready,
    output logic   rsp1_valid,
    output word_t  rsp1_result,
    output logic   rsp1_zero,
    output logic   rsp1_negative,
    output logic   rsp1_overflow,
    input  logic   rsp1_ready,
    output aluop_t alu_op,
    output word_t  alu_a,
    output word_t  alu_b,
    input  word_t  alu_out,
    input  logic   alu_zero,
    input  logic   alu_negative,
    input  logic   alu_overflow
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       free0, free1;
    logic       elig0, elig1;
    logic       grant0, grant1;
    logic [3:0] starve_cnt;
    alu_rsp_t   alu_rsp, rsp0, rsp1;

    assign alu_rsp.result   = alu_out;
    assign alu_rsp.zero     = alu_zero;
    assign alu_rsp.negative = alu_negative;
    assign alu_rsp.overflow = alu_overflow;

    assign elig0  = req0_valid && free0;
    assign elig1  = req1_valid && free1;
    // req1 wins on its own, or under contention once it has lost STARVE_MAX times.
    assign grant1 = elig1 && (!elig0 || starve_cnt == STARVE_LIM);
    assign grant0 = elig0 && !grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_op = ALU_IDLE_OP;
        alu_a  = '0;
        alu_b  = '0;
        if (grant0) begin
            alu_op = req0_op;
            alu_a  = req0_a;
            alu_b  = req0_b;
        end else if (grant1) begin
            alu_op = req1_op;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!req1_valid || grant1) begin
            starve_cnt <= '0;
        end else if (elig1 && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    alu_rsp_slot u_slot0 (
        .CLK       (CLK),
        .nRST      (nRST),
        .load      (grant0),
        .din       (alu_rsp),
        .rsp_ready (rsp0_ready),
        .free      (free0),
        .rsp_valid (rsp0_valid),
        .rsp       (rsp0)
    );

    alu_rsp_slot u_slot1 (
        .CLK       (CLK),
        .nRST      (nRST),
        .load      (grant1),
        .din       (alu_rsp),
        .rsp_ready (rsp1_ready),
        .free      (free1),
        .rsp_valid (rsp1_valid),
        .rsp       (rsp1)
    );

    assign rsp0_result   = rsp0.result;
    assign rsp0_zero     = rsp0.zero;
    assign rsp0_negative = rsp0.negative;
    assign rsp0_overflow = rsp0.overflow;
    assign rsp1_result   = rsp1.result;
    assign rsp1_zero     = rsp1.zero;
    assign rsp1_negative = rsp1.negative;
    assign rsp1_overflow = rsp1.overflow;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU sits behind alu_*, directed vectors
// and sequences cover the corner cases, then randomized traffic runs against a queue model.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int SM    = 4;
    localparam int RSP_W = 35;

    logic   CLK, nRST;
    logic   req0_valid, req1_valid, req0_ready, req1_ready;
    aluop_t req0_op, req1_op, alu_op;
    word_t  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out;
    logic   rsp0_valid, rsp0_zero, rsp0_negative, rsp0_overflow, rsp0_ready;
    logic   rsp1_valid, rsp1_zero, rsp1_negative, rsp1_overflow, rsp1_ready;
    word_t  rsp0_result, rsp1_result;
    logic   alu_zero, alu_negative, alu_overflow;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [RSP_W-1:0] exp_q0[$];
    logic [RSP_W-1:0] exp_q1[$];
    int               m_starve;

    logic   obs_r0, obs_r1;
    aluop_t obs_op;
    word_t  obs_a, obs_b;

    logic   p0_hold, p1_hold;
    aluop_t p0_op, p1_op;
    word_t  p0_a, p0_b, p1_a, p1_b;

    alu_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .nRST(nRST),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp0_negative(rsp0_negative), .rsp0_overflow(rsp0_overflow), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .rsp1_negative(rsp1_negative), .rsp1_overflow(rsp1_overflow), .rsp1_ready(rsp1_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_negative(alu_negative), .alu_overflow(alu_overflow)
    );

    function automatic alu_rsp_t alu_ref(aluop_t op, word_t a, word_t b);
        alu_rsp_t r;
        word_t    res;
        logic     v;
        v = 1'b0;
        case (op)
            ALU_SLL:  res = a << b[4:0];
            ALU_SRL:  res = a >> b[4:0];
            ALU_SRA:  res = word_t'($signed(a) >>> b[4:0]);
            ALU_ADD:  begin res = a + b; v = (a[31] == b[31]) && (res[31] != a[31]); end
            ALU_SUB:  begin res = a - b; v = (a[31] != b[31]) && (res[31] != a[31]); end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLT:  res = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: res = {31'b0, a < b};
            default:  res = '0;
        endcase
        r.result   = res;
        r.zero     = (res == 32'd0);
        r.negative = res[31];
        r.overflow = v;
        return r;
    endfunction

    // Behavioural ALU behind the arbiter.
    alu_rsp_t tb_alu;
    always_comb tb_alu = alu_ref(alu_op, alu_a, alu_b);
    assign alu_out      = tb_alu.result;
    assign alu_zero     = tb_alu.zero;
    assign alu_negative = tb_alu.negative;
    assign alu_overflow = tb_alu.overflow;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare comb outputs and held responses with the model,
    // then advance the model across the rising edge. Called just after a negedge.
    task automatic cycle();
        logic   f0, f1, e0, e1, g0, g1;
        aluop_t eop;
        word_t  ea, eb;
        #1;
        if (p0_hold)
            assert (req0_valid && req0_op == p0_op && req0_a == p0_a && req0_b == p0_b)
            else $error("FAIL proto0: request dropped or changed before ready");
        if (p1_hold)
            assert (req1_valid && req1_op == p1_op && req1_a == p1_a && req1_b == p1_b)
            else $error("FAIL proto1: request dropped or changed before ready");

        f0 = (exp_q0.size() == 0) || rsp0_ready;
        f1 = (exp_q1.size() == 0) || rsp1_ready;
        e0 = req0_valid && f0;
        e1 = req1_valid && f1;
        g1 = e1 && (!e0 || m_starve == SM);
        g0 = e0 && !g1;
        eop = ALU_ADD; ea = '0; eb = '0;
        if (g0) begin eop = req0_op; ea = req0_a; eb = req0_b; end
        else if (g1) begin eop = req1_op; ea = req1_a; eb = req1_b; end

        obs_r0 = req0_ready; obs_r1 = req1_ready;
        obs_op = alu_op; obs_a = alu_a; obs_b = alu_b;
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("alu_op", alu_op, eop);
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("rsp0_valid", rsp0_valid, exp_q0.size() != 0);
        check("rsp1_valid", rsp1_valid, exp_q1.size() != 0);
        if (exp_q0.size() != 0)
            check("rsp0_data", {rsp0_result, rsp0_zero, rsp0_negative, rsp0_overflow}, exp_q0[0]);
        if (exp_q1.size() != 0)
            check("rsp1_data", {rsp1_result, rsp1_zero, rsp1_negative, rsp1_overflow}, exp_q1[0]);
        check("starve_cnt", dut.starve_cnt, m_starve);

        p0_hold = req0_valid && !req0_ready;
        p0_op = req0_op; p0_a = req0_a; p0_b = req0_b;
        p1_hold = req1_valid && !req1_ready;
        p1_op = req1_op; p1_a = req1_a; p1_b = req1_b;

        @(posedge CLK);
        if (exp_q0.size() != 0 && rsp0_ready) void'(exp_q0.pop_front());
        if (exp_q1.size() != 0 && rsp1_ready) void'(exp_q1.pop_front());
        if (g0) exp_q0.push_back(alu_ref(req0_op, req0_a, req0_b));
        if (g1) exp_q1.push_back(alu_ref(req1_op, req1_a, req1_b));
        if (!req1_valid || g1) m_starve = 0;
        else if (e1 && m_starve < SM) m_starve++;
        @(negedge CLK);
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        m_starve = 0;
        p0_hold = 1'b0;
        p1_hold = 1'b0;
    endtask

    task automatic set_req0(input logic v, input aluop_t op, input word_t a, input word_t b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set_req1(input logic v, input aluop_t op, input word_t a, input word_t b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    function automatic word_t rand_word();
        case ($urandom_range(0, 3))
            0:       return word_t'($urandom_range(0, 8));
            1:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        aluop_t op;
        word_t  a;
        word_t  b;
        word_t  res;
        logic   z;
        logic   n;
        logic   v;
    } vec_t;

    vec_t vt[8];
    logic pend0, pend1;

    initial begin
        vt[0] = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b1};
        vt[1] = '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vt[2] = '{ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vt[3] = '{ALU_SLTU, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vt[4] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vt[5] = '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vt[6] = '{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b1, 1'b0};
        vt[7] = '{ALU_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};

        nRST = 1'b0;
        set_req0(1'b0, ALU_ADD, '0, '0);
        set_req1(1'b0, ALU_ADD, '0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        model_reset();
        #1;
        check("reset_rsp0_valid", rsp0_valid, 1'b0);
        check("reset_rsp0_result", rsp0_result, 32'd0);
        check("reset_rsp1_valid", rsp1_valid, 1'b0);
        check("reset_starve", dut.starve_cnt, 4'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // Single requests on req0: accepted in T, result visible in T+1.
        for (int i = 0; i < 8; i++) begin
            set_req0(1'b1, vt[i].op, vt[i].a, vt[i].b);
            cycle();
            check("vec_ready", obs_r0, 1'b1);
            check("vec_valid", rsp0_valid, 1'b1);
            check("vec_rsp", {rsp0_result, rsp0_zero, rsp0_negative, rsp0_overflow},
                  {vt[i].res, vt[i].z, vt[i].n, vt[i].v});
            req0_valid = 1'b0;
        end
        cycle();

        // Contention: grants 0,0,0,0,1 repeating.
        set_req0(1'b1, ALU_ADD, 32'd10, 32'd20);
        set_req1(1'b1, ALU_SUB, 32'd5, 32'd5);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("cont_grant1", obs_r1, (i % 5) == 4);
            check("cont_grant0", obs_r0, (i % 5) != 4);
            if ((i % 5) == 4)
                check("cont_rsp1", {rsp1_result, rsp1_zero}, {32'd0, 1'b1});
        end
        req1_valid = 1'b0;
        cycle();
        check("cont_tail_grant0", obs_r0, 1'b1);
        req0_valid = 1'b0;
        cycle();

        // Backpressure on slot 0.
        rsp0_ready = 1'b0;
        set_req0(1'b1, ALU_OR, 32'hF0, 32'h0F);
        cycle();
        check("bp_first_ready", obs_r0, 1'b1);
        check("bp_first_rsp", rsp0_result, 32'h0000_00FF);
        set_req0(1'b1, ALU_ADD, 32'd1, 32'd1);
        set_req1(1'b1, ALU_XOR, 32'd3, 32'd5);
        cycle();
        check("bp_req0_blocked", obs_r0, 1'b0);
        check("bp_req1_alone", obs_r1, 1'b1);
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold_ready", obs_r0, 1'b0);
            check("bp_hold_valid", rsp0_valid, 1'b1);
            check("bp_hold_rsp", rsp0_result, 32'h0000_00FF);
        end
        rsp0_ready = 1'b1;
        cycle();
        check("bp_regrant", obs_r0, 1'b1);
        check("bp_new_rsp", rsp0_result, 32'd2);
        req0_valid = 1'b0;
        cycle();

        // Drain-and-refill on slot 1.
        set_req1(1'b1, ALU_ADD, 32'd3, 32'd4);
        cycle();
        set_req1(1'b1, ALU_SLTU, 32'd1, 32'd2);
        check("dr_pre_valid", rsp1_valid, 1'b1);
        cycle();
        check("dr_ready", obs_r1, 1'b1);
        check("dr_valid", rsp1_valid, 1'b1);
        check("dr_rsp", rsp1_result, 32'd1);
        req1_valid = 1'b0;

        // Idle.
        repeat (2) cycle();
        check("idle_op", obs_op, ALU_ADD);
        check("idle_a", obs_a, 32'd0);
        check("idle_b", obs_b, 32'd0);
        check("idle_ready", {obs_r0, obs_r1}, 2'b00);
        check("idle_starve", dut.starve_cnt, 4'd0);

        // Reset mid-stream with a held response and starve_cnt at 3.
        set_req0(1'b1, ALU_ADD, 32'd9, 32'd9);
        set_req1(1'b1, ALU_SUB, 32'd5, 32'd5);
        repeat (3) cycle();
        check("rst_pre_valid", rsp0_valid, 1'b1);
        check("rst_pre_starve", dut.starve_cnt, 4'd3);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nRST = 1'b0;
        #1;
        check("rst_async_valid0", rsp0_valid, 1'b0);
        check("rst_async_valid1", rsp1_valid, 1'b0);
        check("rst_async_starve", dut.starve_cnt, 4'd0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cycle();
        check("rst_first_grant0", obs_r0, 1'b1);
        check("rst_first_grant1", obs_r1, 1'b0);

        // Randomized traffic against the queue model.
        pend0 = req0_valid && !obs_r0;
        pend1 = req1_valid && !obs_r1;
        for (int i = 0; i < 600; i++) begin
            if (!pend0) begin
                if ($urandom_range(0, 2) != 0) begin
                    set_req0(1'b1, aluop_t'($urandom_range(0, 10)), rand_word(), rand_word());
                    pend0 = 1'b1;
                end else begin
                    req0_valid = 1'b0;
                end
            end
            if (!pend1) begin
                if ($urandom_range(0, 2) != 0) begin
                    set_req1(1'b1, aluop_t'($urandom_range(0, 10)), rand_word(), rand_word());
                    pend1 = 1'b1;
                end else begin
                    req1_valid = 1'b0;
                end
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 1) != 0);
            cycle();
            if (obs_r0) pend0 = 1'b0;
            if (obs_r1) pend1 = 1'b0;
        end

        // Finish outstanding requests and drain both slots.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!pend0) req0_valid = 1'b0;
            if (!pend1) req1_valid = 1'b0;
            cycle();
            if (obs_r0) pend0 = 1'b0;
            if (obs_r1) pend1 = 1'b0;
        end
        check("end_pending", {pend0, pend1}, 2'b00);
        check("end_drained", {rsp0_valid, rsp1_valid}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
